// File: rtl/event_encoder.sv
// Sequential one-hot-to-binary event encoder: captures request pulses into a
// pending set and presents their indices one at a time over valid/ready.
module event_encoder #(
    parameter int NUM_IN = 4,
    parameter int ADDR_W = 2,
    parameter int DROP_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NUM_IN-1:0] i_in_req,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic [NUM_IN-1:0] o_pending,
    output logic              o_overflow,
    output logic [DROP_W-1:0] o_drop_count
);

    localparam int CNT_W = $clog2(NUM_IN + 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              r_state;
    logic [NUM_IN-1:0]   r_pending;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_overflow;
    logic [DROP_W-1:0]   r_dropCount;

    logic [NUM_IN-1:0]   w_cap;
    logic [NUM_IN-1:0]   w_loadMask;
    logic [NUM_IN-1:0]   w_dropMask;
    logic                w_free;
    logic                w_load;
    logic [ADDR_W-1:0]   w_sel;
    logic [CNT_W-1:0]    w_dropNum;
    logic [DROP_W:0]     w_dropSum;

    assign w_cap  = i_enable ? i_in_req : '0;
    assign w_free = (r_state == EMPTY) || i_out_ready;
    assign w_load = w_free && (r_pending != '0);

    // Scanning downward lets the lowest set bit win, giving bit 0 top priority.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = ADDR_W'(i);
            end
        end
    end

    assign w_loadMask = w_load ? (NUM_IN'(1) << w_sel) : '0;

    // A capture onto a bit still pending is lost unless that bit leaves this cycle.
    assign w_dropMask = w_cap & r_pending & ~w_loadMask;

    always_comb begin
        w_dropNum = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_dropNum = w_dropNum + CNT_W'(w_dropMask[i]);
        end
    end

    assign w_dropSum = {1'b0, r_dropCount} + (DROP_W + 1)'(w_dropNum);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= EMPTY;
            r_pending   <= '0;
            r_addr      <= '0;
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else begin
            r_pending <= (r_pending & ~w_loadMask) | w_cap;
            if (w_load) begin
                r_state <= FULL;
                r_addr  <= w_sel;
            end else if (w_free) begin
                r_state <= EMPTY;
            end
            if (w_dropMask != '0) begin
                r_overflow <= 1'b1;
            end
            // Carry out of the widened sum means the counter would wrap.
            if (w_dropSum[DROP_W]) begin
                r_dropCount <= '1;
            end else begin
                r_dropCount <= w_dropSum[DROP_W-1:0];
            end
        end
    end

    assign o_out_valid  = (r_state == FULL);
    assign o_out_addr   = r_addr;
    assign o_pending    = r_pending;
    assign o_overflow   = r_overflow;
    assign o_drop_count = r_dropCount;

endmodule
